clock_gen_bank: RTL and testbench

//  Parametrised clock generator replacing the fixed divide-by-2/divide-by-4 chain feeding imem/dmem/regfile/processor.

---
 rtl/clock_gen_bank_if.sv | 12 +
 rtl/clock_gen_bank.sv | 114 +++++++++++
 tb/tb_clock_gen_bank.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_gen_bank_if.sv
// Configuration bus for clock_gen_bank: half-period write port plus the error pulse back.
interface clock_gen_bank_if #(
  parameter int DIV_W = 8
);
  logic             cfg_wr;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_err;

  modport master (output cfg_wr, cfg_ch, cfg_half, input cfg_err);
  modport slave  (input cfg_wr, cfg_ch, cfg_half, output cfg_err);
endinterface

// File: rtl/clock_gen_bank.sv
// Bank of NUM_CH registered divided clocks with programmable half-periods, applied only at
// period boundaries, plus per-channel park control, phase-aligning sync and a lock flag.
module clock_gen_bank #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  clock_gen_bank_if.slave   cfg,
  output logic [NUM_CH-1:0] clkOut_o,
  output logic [NUM_CH-1:0] riseTick_o,
  output logic              locked_o
);

  logic [DIV_W-1:0]  cnt_q      [NUM_CH];
  logic [DIV_W-1:0]  cnt_d      [NUM_CH];
  logic [DIV_W-1:0]  half_q     [NUM_CH];
  logic [DIV_W-1:0]  half_d     [NUM_CH];
  logic [DIV_W-1:0]  pendHalf_q [NUM_CH];
  logic [DIV_W-1:0]  pendHalf_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] parked_q, parked_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] pendValid_q, pendValid_d;
  logic              locked_q, locked_d;
  logic              cfgErr_q, cfgErr_d;
  logic              wrOk;

  // A channel falling 1->0 marks its period boundary: pending half-periods and parking take effect only there.
  always_comb begin
    cfgErr_d    = cfg.cfg_wr && ((cfg.cfg_half == '0) || ({1'b0, cfg.cfg_ch} >= 4'(NUM_CH)));
    wrOk        = cfg.cfg_wr && !cfgErr_d;
    cnt_d       = cnt_q;
    half_d      = half_q;
    pendHalf_d  = pendHalf_q;
    clk_d       = clk_q;
    rise_d      = '0;
    parked_d    = parked_q;
    done_d      = done_q;
    pendValid_d = pendValid_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_i) begin
        cnt_d[i]    = '0;
        clk_d[i]    = 1'b0;
        parked_d[i] = !en_i[i];
        done_d[i]   = 1'b0;
        if (pendValid_q[i]) begin
          half_d[i]      = pendHalf_q[i];
          pendValid_d[i] = 1'b0;
        end
      end else if (!(parked_q[i] && !en_i[i])) begin
        parked_d[i] = 1'b0;
        if (cnt_q[i] == half_q[i] - DIV_W'(1)) begin
          cnt_d[i] = '0;
          clk_d[i] = !clk_q[i];
          if (!clk_q[i]) begin
            rise_d[i] = 1'b1;
          end else begin
            done_d[i]   = 1'b1;
            parked_d[i] = !en_i[i];
            if (pendValid_q[i]) begin
              half_d[i]      = pendHalf_q[i];
              pendValid_d[i] = 1'b0;
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
      if (wrOk && (cfg.cfg_ch == 3'(i))) begin
        pendValid_d[i] = 1'b1;
        pendHalf_d[i]  = cfg.cfg_half;
      end
    end
    locked_d = !sync_i && (locked_q || (&(done_d | parked_d | ~en_i)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        half_q[i]     <= DIV_W'(1) << i;
        pendHalf_q[i] <= '0;
      end
      clk_q       <= '0;
      rise_q      <= '0;
      parked_q    <= '1;
      done_q      <= '0;
      pendValid_q <= '0;
      locked_q    <= 1'b0;
      cfgErr_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pendHalf_q  <= pendHalf_d;
      clk_q       <= clk_d;
      rise_q      <= rise_d;
      parked_q    <= parked_d;
      done_q      <= done_d;
      pendValid_q <= pendValid_d;
      locked_q    <= locked_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  assign clkOut_o    = clk_q;
  assign riseTick_o  = rise_q;
  assign locked_o    = locked_q;
  assign cfg.cfg_err = cfgErr_q;

endmodule

// File: tb/tb_clock_gen_bank.sv
// Directed bench for clock_gen_bank: per-cycle tables after reset and after sync, plus
// hand-written sequences for reprogramming, config errors, parking and async reset.
module tb_clock_gen_bank;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] en;
  logic       syncPulse;
  logic [3:0] clkOut;
  logic [3:0] riseTick;
  logic       locked;

  clock_gen_bank_if #(.DIV_W(DIV_W)) cfgBus ();

  clock_gen_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .en_i       (en),
    .sync_i     (syncPulse),
    .cfg        (cfgBus),
    .clkOut_o   (clkOut),
    .riseTick_o (riseTick),
    .locked_o   (locked)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] clk;
    logic [3:0] rise;
    logic       lock;
  } vec_t;

  vec_t resetVec [20];
  vec_t syncVec  [18];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [2:0] ch, input logic [7:0] half, input logic s);
    cfgBus.cfg_wr   = wr;
    cfgBus.cfg_ch   = ch;
    cfgBus.cfg_half = half;
    syncPulse       = s;
  endtask

  task automatic runResetTable();
    for (int n = 0; n < 20; n++) begin
      if (n > 0) tick();
      checkOutput("rst_clk",  8'(clkOut),   8'(resetVec[n].clk));
      checkOutput("rst_rise", 8'(riseTick), 8'(resetVec[n].rise));
      checkOutput("rst_lock", 8'(locked),   8'(resetVec[n].lock));
    end
  endtask

  logic [10:0] pat2a;
  logic [11:0] pat2b;
  logic [11:0] pat3;

  initial begin
    // halves 1,2,4,8 from reset make clk_out count in binary; rise is the lowest set bit of n
    resetVec[0]  = '{4'h0, 4'h0, 1'b0};
    resetVec[1]  = '{4'h1, 4'h1, 1'b0};
    resetVec[2]  = '{4'h2, 4'h2, 1'b0};
    resetVec[3]  = '{4'h3, 4'h1, 1'b0};
    resetVec[4]  = '{4'h4, 4'h4, 1'b0};
    resetVec[5]  = '{4'h5, 4'h1, 1'b0};
    resetVec[6]  = '{4'h6, 4'h2, 1'b0};
    resetVec[7]  = '{4'h7, 4'h1, 1'b0};
    resetVec[8]  = '{4'h8, 4'h8, 1'b0};
    resetVec[9]  = '{4'h9, 4'h1, 1'b0};
    resetVec[10] = '{4'hA, 4'h2, 1'b0};
    resetVec[11] = '{4'hB, 4'h1, 1'b0};
    resetVec[12] = '{4'hC, 4'h4, 1'b0};
    resetVec[13] = '{4'hD, 4'h1, 1'b0};
    resetVec[14] = '{4'hE, 4'h2, 1'b0};
    resetVec[15] = '{4'hF, 4'h1, 1'b0};
    resetVec[16] = '{4'h0, 4'h0, 1'b1};
    resetVec[17] = '{4'h1, 4'h1, 1'b1};
    resetVec[18] = '{4'h2, 4'h2, 1'b1};
    resetVec[19] = '{4'h3, 4'h1, 1'b1};
    // after sync: ch0 h=1 then pending h=2, ch1 h=2, ch2 h=2, ch3 h=8
    syncVec[0]  = '{4'h0, 4'h0, 1'b0};
    syncVec[1]  = '{4'h1, 4'h1, 1'b0};
    syncVec[2]  = '{4'h6, 4'h6, 1'b0};
    syncVec[3]  = '{4'h6, 4'h0, 1'b0};
    syncVec[4]  = '{4'h1, 4'h1, 1'b0};
    syncVec[5]  = '{4'h1, 4'h0, 1'b0};
    syncVec[6]  = '{4'h6, 4'h6, 1'b0};
    syncVec[7]  = '{4'h6, 4'h0, 1'b0};
    syncVec[8]  = '{4'h9, 4'h9, 1'b0};
    syncVec[9]  = '{4'h9, 4'h0, 1'b0};
    syncVec[10] = '{4'hE, 4'h6, 1'b0};
    syncVec[11] = '{4'hE, 4'h0, 1'b0};
    syncVec[12] = '{4'h9, 4'h1, 1'b0};
    syncVec[13] = '{4'h9, 4'h0, 1'b0};
    syncVec[14] = '{4'hE, 4'h6, 1'b0};
    syncVec[15] = '{4'hE, 4'h0, 1'b0};
    syncVec[16] = '{4'h1, 4'h1, 1'b1};
    syncVec[17] = '{4'h1, 4'h0, 1'b1};
    pat2a = 11'b10001110001;
    pat2b = 12'b001100111000;
    pat3  = 12'b110011001111;

    reset = 1'b1;
    en    = 4'hF;
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("in_reset_clk", 8'(clkOut), 8'h00);
    reset = 1'b0;
    cyc   = 0;
    $display("[TB] reset release table");
    runResetTable();

    // ch1 h=3 written mid high phase; current period completes first
    runTo(22);
    applyStimulus(1'b1, 3'd1, 8'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    checkOutput("legal_wr_no_err", 8'(cfgBus.cfg_err), 8'h00);
    for (int n = 23; n <= 33; n++) begin
      runTo(n);
      checkOutput("ch1_reprog", 8'(clkOut[1]), 8'(pat2a[n-23]));
      if (n == 27) checkOutput("ch1_rise_h3", 8'(riseTick[1]), 8'h01);
    end

    // write exactly on the boundary edge: one more old period first
    runTo(35);
    applyStimulus(1'b1, 3'd1, 8'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    for (int n = 36; n <= 47; n++) begin
      runTo(n);
      checkOutput("ch1_boundary_wr", 8'(clkOut[1]), 8'(pat2b[n-36]));
    end

    // two writes to ch2 before its boundary: only the last is used
    runTo(49);
    applyStimulus(1'b1, 3'd2, 8'd5, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd2, 8'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    for (int n = 52; n <= 63; n++) begin
      runTo(n);
      checkOutput("ch2_last_wr", 8'(clkOut[2]), 8'(pat3[n-52]));
      if (n == 58) checkOutput("ch2_rise", 8'(riseTick[2]), 8'h01);
    end

    // illegal writes pulse cfg_err and change nothing
    runTo(64);
    applyStimulus(1'b1, 3'd0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    checkOutput("err_half0", 8'(cfgBus.cfg_err), 8'h01);
    tick();
    checkOutput("err_pulse_end", 8'(cfgBus.cfg_err), 8'h00);
    checkOutput("ch2_after_err", 8'(clkOut[2]), 8'h01);
    applyStimulus(1'b1, 3'd5, 8'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    checkOutput("err_bad_ch", 8'(cfgBus.cfg_err), 8'h01);
    checkOutput("ch0_after_err", 8'(clkOut[0]), 8'h01);
    tick();
    checkOutput("ch0_after_err2", 8'(clkOut[0]), 8'h00);
    checkOutput("ch2_after_err2", 8'(clkOut[2]), 8'h00);

    // drop en[3] while high: finish the high phase, then park
    runTo(73);
    en = 4'h7;
    runTo(79);
    checkOutput("ch3_high_kept", 8'(clkOut[3]), 8'h01);
    for (int n = 80; n <= 95; n++) begin
      runTo(n);
      checkOutput("ch3_parked", 8'({clkOut[3], riseTick[3]}), 8'h00);
    end
    checkOutput("lock_while_parked", 8'(locked), 8'h01);
    en = 4'hF;
    runTo(102);
    checkOutput("ch3_restart_low", 8'(clkOut[3]), 8'h00);
    tick();
    checkOutput("ch3_restart_rise", 8'({clkOut[3], riseTick[3]}), 8'h03);
    checkOutput("lock_after_restart", 8'(locked), 8'h01);

    // sync with a same-cycle write to ch0 that must only pend
    runTo(110);
    applyStimulus(1'b1, 3'd0, 8'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    $display("[TB] post-sync table");
    for (int k = 0; k < 18; k++) begin
      if (k > 0) tick();
      checkOutput("sync_clk",  8'(clkOut),   8'(syncVec[k].clk));
      checkOutput("sync_rise", 8'(riseTick), 8'(syncVec[k].rise));
      checkOutput("sync_lock", 8'(locked),   8'(syncVec[k].lock));
    end

    // async reset between edges clears everything including pending config
    applyStimulus(1'b1, 3'd1, 8'd7, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_clk",  8'(clkOut), 8'h00);
    checkOutput("async_rst_lock", 8'(locked), 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
    $display("[TB] second reset release table");
    runResetTable();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
